// File: rtl/board_pkg.sv
`default_nettype none
// ============================================================================
// Module      : board_pkg
// Description : Shared types, default widths/colours and the {y,x} address
//               pack helper for the board renderer.
// Revision    : 1.0 - initial release
// ============================================================================
package board_pkg;

    localparam int GRID_BITS_DEF = 4;
    localparam int COLOUR_W_DEF  = 3;
    localparam int ADDR_W_DEF    = 2 * GRID_BITS_DEF;
    localparam int PACK_W        = 16;

    localparam logic [COLOUR_W_DEF-1:0] BG_COLOUR_DEF   = 3'b000;
    localparam logic [COLOUR_W_DEF-1:0] COLL_COLOUR_DEF = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LATCH = 3'd2,
        S_WRITE = 3'd3,
        S_RD    = 3'd4,
        S_WAIT  = 3'd5,
        S_DRAW  = 3'd6,
        S_DONE  = 3'd7
    } state_e;

    // Caller truncates the result to 2*gb bits.
    function automatic logic [PACK_W-1:0] pack_addr(input logic [7:0] y,
                                                    input logic [7:0] x,
                                                    input int gb);
        return (PACK_W'(y) << gb) | PACK_W'(x);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tile_painter.sv
`default_nettype none
// ============================================================================
// Module      : tile_painter
// Description : Emits a TILE_PX x TILE_PX square of pixels in raster order,
//               one per cycle, starting the cycle after start.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_painter #(
    parameter int TILE_PX  = 30,
    parameter int COLOUR_W = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [9:0]          org_x,
    input  logic [8:0]          org_y,
    input  logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic [9:0]          vga_x,
    output logic [8:0]          vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                last
);

    localparam logic [9:0] LAST_PX = 10'(TILE_PX - 1);

    logic [9:0]          px_q, px_d, py_q, py_d, ox_q, ox_d, x_q, x_d;
    logic [8:0]          oy_q, oy_d, y_q, y_d;
    logic [COLOUR_W-1:0] col_q, col_d;
    logic                plot_q, plot_d, last_q, last_d;

    always_comb begin
        px_d   = px_q;
        py_d   = py_q;
        ox_d   = ox_q;
        oy_d   = oy_q;
        x_d    = x_q;
        y_d    = y_q;
        col_d  = col_q;
        plot_d = plot_q;
        last_d = last_q;
        if (start) begin
            ox_d   = org_x;
            oy_d   = org_y;
            col_d  = colour;
            px_d   = '0;
            py_d   = '0;
            x_d    = org_x;
            y_d    = org_y;
            plot_d = 1'b1;
            last_d = (TILE_PX == 1);
        end else if (plot_q && !last_q) begin
            if (px_q == LAST_PX) begin
                px_d = '0;
                py_d = py_q + 10'd1;
            end else begin
                px_d = px_q + 10'd1;
            end
            x_d    = ox_q + px_d;
            y_d    = oy_q + 9'(py_d);
            last_d = (px_d == LAST_PX) && (py_d == LAST_PX);
        end else if (plot_q) begin
            plot_d = 1'b0;
            last_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            px_q   <= '0;
            py_q   <= '0;
            ox_q   <= '0;
            oy_q   <= '0;
            x_q    <= '0;
            y_q    <= '0;
            col_q  <= '0;
            plot_q <= 1'b0;
            last_q <= 1'b0;
        end else begin
            px_q   <= px_d;
            py_q   <= py_d;
            ox_q   <= ox_d;
            oy_q   <= oy_d;
            x_q    <= x_d;
            y_q    <= y_d;
            col_q  <= col_d;
            plot_q <= plot_d;
            last_q <= last_d;
        end
    end

    assign plot       = plot_q;
    assign vga_x      = x_q;
    assign vga_y      = y_q;
    assign vga_colour = col_q;
    assign last       = last_q;

endmodule
`default_nettype wire

// File: rtl/board_render_fsm.sv
`default_nettype none
// ============================================================================
// Module      : board_render_fsm
// Description : Writes player tiles into the board RAM, then sweeps the RAM
//               and streams each tile to the VGA adapter. Defining
//               COLLISION_EN enables shared-tile collision detection.
// Revision    : 1.0 - initial release
// ============================================================================
module board_render_fsm
    import board_pkg::*;
#(
    parameter int                  GRID_BITS   = GRID_BITS_DEF,
    parameter int                  NUM_PLAYERS = 2,
    parameter int                  TILE_PX     = 30,
    parameter int                  X_OFF       = 80,
    parameter int                  Y_OFF       = 0,
    parameter int                  COLOUR_W    = COLOUR_W_DEF,
    parameter logic [COLOUR_W-1:0] BG_COLOUR   = COLOUR_W'(BG_COLOUR_DEF),
    parameter logic [COLOUR_W-1:0] COLL_COLOUR = COLOUR_W'(COLL_COLOUR_DEF)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            frame_start,
    input  logic                            board_clear,
    input  logic [NUM_PLAYERS*GRID_BITS-1:0] pos_x,
    input  logic [NUM_PLAYERS*GRID_BITS-1:0] pos_y,
    input  logic [NUM_PLAYERS*COLOUR_W-1:0]  player_colour,
    output logic [2*GRID_BITS-1:0]          mem_addr,
    output logic                            mem_we,
    output logic [COLOUR_W-1:0]             mem_wdata,
    input  logic [COLOUR_W-1:0]             mem_rdata,
    output logic [9:0]                      vga_x,
    output logic [8:0]                      vga_y,
    output logic [COLOUR_W-1:0]             vga_colour,
    output logic                            plot,
    output logic                            busy,
    output logic                            done,
    output logic [NUM_PLAYERS-1:0]          collision
);

    localparam int                ADDR_W = 2 * GRID_BITS;
    localparam int                PW     = NUM_PLAYERS * GRID_BITS;
    localparam int                CW     = NUM_PLAYERS * COLOUR_W;
    localparam logic [ADDR_W-1:0] LAST_T = '1;
    localparam logic [1:0]        LAST_P = 2'(NUM_PLAYERS - 1);

    if (NUM_PLAYERS < 1 || NUM_PLAYERS > 4 || GRID_BITS < 1 || GRID_BITS > 8 ||
        TILE_PX < 1 || (1 << GRID_BITS) * TILE_PX + X_OFF > 640 ||
        (1 << GRID_BITS) * TILE_PX + Y_OFF > 480) begin : g_param_err
        $error("board_render_fsm: illegal parameter combination");
    end

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     t_q, t_d, mem_addr_q, mem_addr_d;
    logic [1:0]            p_q, p_d;
    logic                  mem_we_q, mem_we_d, busy_q, busy_d, done_q, done_d;
    logic [COLOUR_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [NUM_PLAYERS-1:0] collision_q, collision_d, w_coll;
    logic [PW-1:0]         lat_x_q, lat_x_d, lat_y_q, lat_y_d;
    logic [CW-1:0]         lat_col_q, lat_col_d;

`ifdef COLLISION_EN
    always_comb begin
        w_coll = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            for (int j = 0; j < NUM_PLAYERS; j++) begin
                if (i != j &&
                    pos_x[i*GRID_BITS +: GRID_BITS] == pos_x[j*GRID_BITS +: GRID_BITS] &&
                    pos_y[i*GRID_BITS +: GRID_BITS] == pos_y[j*GRID_BITS +: GRID_BITS])
                    w_coll[i] = 1'b1;
            end
        end
    end
`else
    assign w_coll = '0;
`endif

    // Player 0 is written straight out of LATCH, before the latches update.
    logic                 w_in_latch, w_wcoll, w_last;
    logic [PW-1:0]        w_src_x, w_src_y;
    logic [CW-1:0]        w_src_col;
    logic [3:0]           w_src_coll;
    logic [1:0]           w_wp;
    logic [GRID_BITS-1:0] w_wx, w_wy, w_tx, w_ty;
    logic [COLOUR_W-1:0]  w_wcol, w_wdata;
    logic [ADDR_W-1:0]    w_waddr;
    logic [9:0]           w_org_x;
    logic [8:0]           w_org_y;

    assign w_in_latch = (state_q == S_LATCH);
    assign w_src_x    = w_in_latch ? pos_x : lat_x_q;
    assign w_src_y    = w_in_latch ? pos_y : lat_y_q;
    assign w_src_col  = w_in_latch ? player_colour : lat_col_q;
    assign w_src_coll = 4'(w_in_latch ? w_coll : collision_q);
    assign w_wp       = w_in_latch ? 2'd0 : p_q + 2'd1;
    assign w_wx       = w_src_x[w_wp*GRID_BITS +: GRID_BITS];
    assign w_wy       = w_src_y[w_wp*GRID_BITS +: GRID_BITS];
    assign w_wcol     = w_src_col[w_wp*COLOUR_W +: COLOUR_W];
    assign w_wcoll    = w_src_coll[w_wp];
    assign w_wdata    = w_wcoll ? COLL_COLOUR : w_wcol;
    assign w_waddr    = ADDR_W'(pack_addr(8'(w_wy), 8'(w_wx), GRID_BITS));

    assign w_tx    = t_q[GRID_BITS-1:0];
    assign w_ty    = t_q[ADDR_W-1:GRID_BITS];
    assign w_org_x = 10'(X_OFF) + 10'(w_tx) * 10'(TILE_PX);
    assign w_org_y = 9'(Y_OFF) + 9'(w_ty) * 9'(TILE_PX);

    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        p_d         = p_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        collision_d = collision_q;
        lat_x_d     = lat_x_q;
        lat_y_d     = lat_y_q;
        lat_col_d   = lat_col_q;
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    t_d = '0;
                    if (board_clear) begin
                        state_d     = S_CLEAR;
                        mem_addr_d  = '0;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = BG_COLOUR;
                    end else begin
                        state_d = S_LATCH;
                    end
                end
            end
            S_CLEAR: begin
                if (t_q == LAST_T) begin
                    state_d = S_LATCH;
                    t_d     = '0;
                end else begin
                    t_d        = t_q + 1'b1;
                    mem_addr_d = t_q + 1'b1;
                    mem_we_d   = 1'b1;
                end
            end
            S_LATCH: begin
                lat_x_d     = pos_x;
                lat_y_d     = pos_y;
                lat_col_d   = player_colour;
                collision_d = w_coll;
                p_d         = 2'd0;
                t_d         = '0;
                state_d     = S_WRITE;
                mem_addr_d  = w_waddr;
                mem_we_d    = 1'b1;
                mem_wdata_d = w_wdata;
            end
            S_WRITE: begin
                if (p_q == LAST_P) begin
                    state_d    = S_RD;
                    mem_addr_d = '0;
                end else begin
                    p_d         = p_q + 2'd1;
                    mem_addr_d  = w_waddr;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = w_wdata;
                end
            end
            S_RD:   state_d = S_WAIT;
            S_WAIT: state_d = S_DRAW;
            S_DRAW: begin
                if (w_last) begin
                    if (t_q == LAST_T) begin
                        state_d = S_DONE;
                    end else begin
                        t_d        = t_q + 1'b1;
                        mem_addr_d = t_q + 1'b1;
                        state_d    = S_RD;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            t_q         <= '0;
            p_q         <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            collision_q <= '0;
            lat_x_q     <= '0;
            lat_y_q     <= '0;
            lat_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            p_q         <= p_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            collision_q <= collision_d;
            lat_x_q     <= lat_x_d;
            lat_y_q     <= lat_y_d;
            lat_col_q   <= lat_col_d;
        end
    end

    // RAM data is valid during WAIT, so the painter latches it there.
    tile_painter #(
        .TILE_PX  (TILE_PX),
        .COLOUR_W (COLOUR_W)
    ) u_painter (
        .clock      (clock),
        .reset      (reset),
        .start      (state_q == S_WAIT),
        .org_x      (w_org_x),
        .org_y      (w_org_y),
        .colour     (mem_rdata),
        .plot       (plot),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .last       (w_last)
    );

    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign collision = collision_q;

endmodule
`default_nettype wire

// File: tb/tb_board_render_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_board_render_fsm
// Description : Self-checking bench for board_render_fsm on a 4x4 board with
//               2x2-pixel tiles; follows COLLISION_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_board_render_fsm;

    localparam int NT = 16;
    localparam int TP = 2;
    localparam int NP = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       frame_start = 1'b0, board_clear = 1'b0;
    logic [3:0] pos_x = '0, pos_y = '0;
    logic [5:0] player_colour = '0;
    logic [3:0] mem_addr;
    logic       mem_we, plot, busy, done;
    logic [2:0] mem_wdata, mem_rdata, vga_colour;
    logic [9:0] vga_x;
    logic [8:0] vga_y;
    logic [1:0] collision;

    board_render_fsm #(
        .GRID_BITS(2), .NUM_PLAYERS(2), .TILE_PX(2), .X_OFF(0), .Y_OFF(0),
        .COLOUR_W(3), .BG_COLOUR(3'b000), .COLL_COLOUR(3'b110)
    ) dut (
        .clock(clock), .reset(reset), .frame_start(frame_start), .board_clear(board_clear),
        .pos_x(pos_x), .pos_y(pos_y), .player_colour(player_colour),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .plot(plot),
        .busy(busy), .done(done), .collision(collision)
    );

    always #5 clock = ~clock;

    // Board RAM with one cycle of read latency; stub mode returns the address.
    logic [2:0] ram [16] = '{default: 3'b000};
    logic [2:0] rdata_q = '0;
    bit         stub_mode = 1'b0;
    always @(posedge clock) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        rdata_q <= stub_mode ? mem_addr[2:0] : ram[mem_addr];
    end
    assign mem_rdata = rdata_q;

    int         tests = 0, fails = 0;
    logic [6:0] wq[$];
    logic [21:0] pq[$];
    logic [2:0] model_board [16] = '{default: 3'b000};
    logic [2:0] screen [8][8];
    int         plot_cnt = 0;
    bit         chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en && reset) begin
            if (mem_we) begin
                if (wq.size() == 0) check("write_expected", {mem_addr, mem_wdata}, 32'hFFFF_FFFF);
                else check("mem_write", {mem_addr, mem_wdata}, wq.pop_front());
            end
            if (plot) begin
                plot_cnt++;
                if (vga_x < 10'd8 && vga_y < 9'd8) screen[vga_y][vga_x] = vga_colour;
                if (pq.size() == 0) check("pixel_expected", {vga_x, vga_y, vga_colour}, 32'hFFFF_FFFF);
                else check("pixel", {vga_x, vga_y, vga_colour}, pq.pop_front());
            end
        end
    end

    task automatic run_frame(input bit clr, input logic [3:0] xs, input logic [3:0] ys,
                             input logic [5:0] cols, input bit stub, input int pulse_at,
                             input int abort_at, output int len);
        logic [1:0] coll;
        logic [2:0] c;
        int a, exp_len, cyc, mism;
        coll = '0;
`ifdef COLLISION_EN
        for (int p = 0; p < NP; p++)
            for (int q = 0; q < NP; q++)
                if (p != q && xs[p*2 +: 2] == xs[q*2 +: 2] && ys[p*2 +: 2] == ys[q*2 +: 2])
                    coll[p] = 1'b1;
`endif
        wq.delete();
        pq.delete();
        plot_cnt = 0;
        for (int y = 0; y < 8; y++) for (int x = 0; x < 8; x++) screen[y][x] = 3'b000;
        if (clr) for (int i = 0; i < NT; i++) begin
            wq.push_back({4'(i), 3'b000});
            model_board[i] = 3'b000;
        end
        for (int p = 0; p < NP; p++) begin
            a = int'(ys[p*2 +: 2]) * 4 + int'(xs[p*2 +: 2]);
            c = coll[p] ? 3'b110 : cols[p*3 +: 3];
            wq.push_back({4'(a), c});
            model_board[a] = c;
        end
        for (int t = 0; t < NT; t++) begin
            c = stub ? 3'(t) : model_board[t];
            for (int py = 0; py < TP; py++)
                for (int px = 0; px < TP; px++)
                    pq.push_back({10'((t % 4) * TP + px), 9'((t / 4) * TP + py), c});
        end
        exp_len = 1 + (clr ? NT : 0) + 1 + NP + NT * (2 + TP * TP) + 1;
        stub_mode = stub;

        @(negedge clock);
        board_clear = clr; pos_x = xs; pos_y = ys; player_colour = cols; frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0; board_clear = 1'b0;
        cyc = 2;
        check("busy_rise", busy, 1);
        while (done !== 1'b1 && cyc < 1000) begin
            if (cyc == 30) begin
                pos_x = 4'($urandom); pos_y = 4'($urandom); player_colour = 6'($urandom);
            end
            frame_start = (cyc == pulse_at);
            board_clear = (cyc == pulse_at);
            if (cyc == abort_at) begin
                check("pre_abort_plot", plot, 1);
                #2 reset = 1'b0;
                #1;
                check("abort_plot", plot, 0);
                check("abort_busy", busy, 0);
                chk_en = 1'b0;
                @(negedge clock);
                @(negedge clock);
                reset = 1'b1;
                wq.delete();
                pq.delete();
                chk_en = 1'b1;
                stub_mode = 1'b0;
                len = cyc;
                return;
            end
            @(negedge clock);
            cyc++;
        end
        frame_start = 1'b0; board_clear = 1'b0;
        check("done_seen", done, 1);
        check("frame_len", cyc, exp_len);
        @(negedge clock);
        check("done_single", done, 0);
        check("busy_idle", busy, 0);
        check("writes_left", wq.size(), 0);
        check("pixels_left", pq.size(), 0);
        check("collision", collision, coll);
        mism = 0;
        for (int i = 0; i < NT; i++) if (ram[i] !== model_board[i]) mism++;
        check("board_ram", mism, 0);
        stub_mode = 1'b0;
        len = cyc;
    endtask

    int len;

    initial begin
        repeat (3) @(negedge clock);
        check("rst_mem_we", mem_we, 0);
        check("rst_plot", plot, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_collision", collision, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_vga", {vga_x, vga_y, vga_colour}, 0);
        reset = 1'b1;
        chk_en = 1'b1;
        @(negedge clock);

        // P0=(1,0) red, P1=(3,3) blue, cleared board.
        run_frame(1'b1, {2'd3, 2'd1}, {2'd3, 2'd0}, {3'b001, 3'b100}, 1'b0, 0, 0, len);
        check("A_len", len, 117);
        check("A_plots", plot_cnt, 64);
        check("A_addr1", ram[1], 3'b100);
        check("A_addr15", ram[15], 3'b001);
        check("A_px_2_0", screen[0][2], 3'b100);
        check("A_px_7_7", screen[7][7], 3'b001);

        // P0 moves to (2,0) without clearing: old tile stays.
        run_frame(1'b0, {2'd3, 2'd2}, {2'd3, 2'd0}, {3'b001, 3'b100}, 1'b0, 0, 0, len);
        check("B_len", len, 101);
        check("B_trail_addr1", ram[1], 3'b100);
        check("B_new_addr2", ram[2], 3'b100);

        // Both players on (2,1).
        run_frame(1'b1, {2'd2, 2'd2}, {2'd1, 2'd1}, {3'b001, 3'b100}, 1'b0, 0, 0, len);
`ifdef COLLISION_EN
        check("C_addr6", ram[6], 3'b110);
        check("C_coll", collision, 2'b11);
`else
        check("C_addr6", ram[6], 3'b001);
        check("C_coll", collision, 2'b00);
`endif

        // frame_start and board_clear pulsed mid-DRAW are ignored.
        run_frame(1'b0, 4'($urandom), 4'($urandom), 6'($urandom), 1'b0, 62, 0, len);
        check("D_len", len, 101);

        run_frame(1'b1, 4'($urandom), 4'($urandom), 6'($urandom), 1'b0, 0, 72, len);
        run_frame(1'b1, 4'($urandom), 4'($urandom), 6'($urandom), 1'b0, 0, 0, len);
        check("F_len", len, 117);

        run_frame(1'b0, 4'($urandom), 4'($urandom), 6'($urandom), 1'b1, 0, 0, len);

        for (int k = 0; k < 4; k++)
            run_frame(1'($urandom), 4'($urandom), 4'($urandom), 6'($urandom), 1'b0, 0, 0, len);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/board_render_fsm.md
# board_render_fsm

Parametrised board renderer for the game display. On each frame request it latches all player tile positions and writes their colours into the external board RAM, flagging shared tiles as collisions. It then sweeps every tile of the board RAM and streams each tile as a filled square of pixels to the VGA adapter. It sits between the player FSMs and the VGA adapter, and owns the board RAM write and read port.

## Interface
Parameters:
- GRID_BITS, 4: board is 2^GRID_BITS × 2^GRID_BITS tiles (N = 2^GRID_BITS).
- NUM_PLAYERS, 2: number of players, range 1..4.
- TILE_PX, 30: tile edge in pixels. N*TILE_PX + X_OFF must be ≤ 640, and N*TILE_PX + Y_OFF ≤ 480.
- X_OFF, 80; Y_OFF, 0: pixel origin of tile (0,0).
- COLOUR_W, 3: colour width.
- BG_COLOUR, 3'b000; COLL_COLOUR, 3'b110: background colour and collision colour.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle request. Ignored while busy.
- board_clear  in  1  sampled with frame_start. When high, the whole RAM is cleared before the player writes.
- pos_x, pos_y  in  NUM_PLAYERS*GRID_BITS each  packed player coordinates. Player p occupies bits [p*GRID_BITS +: GRID_BITS].
- player_colour  in  NUM_PLAYERS*COLOUR_W  packed colour for each player.
- mem_addr  out  2*GRID_BITS  RAM address = {y,x}.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  COLOUR_W  RAM write data.
- mem_rdata  in  COLOUR_W  RAM read data. Read latency is exactly 1 cycle.
- vga_x  out  10; vga_y  out  9; vga_colour  out  COLOUR_W; plot  out  1  pixel stream.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on completion of a frame.
- collision  out  NUM_PLAYERS  per-player collision flags, held until the next LATCH.

## Operation
- States: IDLE → [CLEAR] → LATCH → WRITE → RD → WAIT → DRAW → (RD | DONE) → IDLE.
- IDLE: waits for frame_start. Captures board_clear at the same time.
- CLEAR: writes BG_COLOUR to addresses 0..N²−1, one per cycle. mem_we is high throughout.
- LATCH: registers all positions and colours. Computes pairwise equality of positions and updates collision[].
- WRITE: one cycle per player, p = 0..NUM_PLAYERS−1. Writes mem_addr = {y_p, x_p}. Data is COLL_COLOUR if collision[p], otherwise the player's colour. Tiles written in earlier frames persist, so trails remain.
- RD: drives mem_addr = tile index t with mem_we = 0.
- WAIT: captures mem_rdata into the tile colour register.
- DRAW: the tile painter emits TILE_PX² pixels in raster order, one per cycle with plot high. Pixel coordinates:
  - vga_x = X_OFF + tx*TILE_PX + px
  - vga_y = Y_OFF + ty*TILE_PX + py
  - tx = t[GRID_BITS−1:0], ty = t[2*GRID_BITS−1:GRID_BITS].
- On the painter's last pixel: if t = N²−1, go to DONE; otherwise increment t and go to RD.
- DONE: done = 1 for one cycle, then IDLE.
- Tile index wraps from N²−1 to 0 only through DONE. Never wraps mid-sweep.
- frame_start or board_clear asserted while busy: ignored, with no queueing.
- Reset deassertion mid-operation is not special-cased. Asynchronous assertion forces IDLE immediately.

## Timing
- Reset values:
  - State IDLE; mem_we, plot, busy, done all 0.
  - collision = 0, mem_addr = 0, mem_wdata = 0, vga_x = vga_y = 0, vga_colour = 0.
- busy rises the cycle after frame_start is sampled.
- Frame length in cycles from frame_start to done: 1 + [N² if clear] + 1 + NUM_PLAYERS + N²·(2 + TILE_PX²) + 1.
- All outputs are registered. plot, vga_x, vga_y and vga_colour change together.
- Arithmetic: pixel coordinates are computed at 10 bits and 9 bits, with no saturation. Parameter legality is checked at elaboration.

## Configuration
- COLLISION_EN defined: behaviour exactly as above.
- COLLISION_EN undefined:
  - No comparators are built, and collision is tied to 0.
  - WRITE always writes each player's own colour.
  - Where positions coincide, the highest-index player's write lands last and wins.

## Structure
- Package board_pkg holds:
  - state enum;
  - addr/colour width localparams derived from GRID_BITS and COLOUR_W;
  - BG_COLOUR and COLL_COLOUR defaults;
  - a {y,x} address-pack function.
- Sub-module tile_painter:
  - inputs: start, origin x/y, colour;
  - outputs: a TILE_PX×TILE_PX raster of pixels, with last asserted on the final pixel;
  - contains its own px/py counters.

## Test plan
- Config GRID_BITS=2, TILE_PX=2, NUM_PLAYERS=2, X_OFF=0. Reset, then frame_start with board_clear=1, P0=(1,0) red 100, P1=(3,3) blue 001.
  - Required: 16 clear writes, then writes addr 1 ← 100 and addr 15 ← 001.
  - 64 plots in total; pixel (2,0) colour 100, pixel (7,7) colour 001.
  - done exactly 1+16+1+2+16·6+1 = 117 cycles after frame_start.
- Same config, P0=P1=(2,1), COLLISION_EN defined → addr 6 ← 110, collision = 2'b11. Undefined → addr 6 ← P1 colour, collision = 0.
- Second frame with board_clear=0 after P0 moves (1,0)→(2,0) → addr 1 still reads 100 and addr 2 becomes 100 (trail persists).
- frame_start pulsed mid-DRAW → no restart; done pulses once; the frame length is unchanged.
- reset driven low mid-sweep → same-cycle plot = 0, busy = 0; a following frame_start completes a normal frame.
- mem_rdata stub returns the address as its value → every tile's pixels carry colour = t[2:0], confirming the 1-cycle read alignment.
